mac_seq_ctrl: RTL and testbench
===============================

MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 SHALL have parameter row, default 8: number of mac_tile rows; kernel-load vectors per run.
REQ-002 SHALL have parameter col, default 8: number of mac_tile columns in the array.
REQ-003 SHALL have parameter addr_bw, default 11: SRAM address width.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset (reset=0 resets at the rising edge).
REQ-006 SHALL have port start  input  1  run request, sampled only in IDLE.
REQ-007 SHALL have port len  input  8  number of execute vectors, latched on accepted start.
REQ-008 SHALL have port k_base  input  addr_bw  kernel base address, latched on accepted start.
REQ-009 SHALL have port x_base  input  addr_bw  activation base address, latched on accepted start.
REQ-010 SHALL have port stall  input  1  freeze request from the downstream/SRAM side.
REQ-011 SHALL have port rd_en  output  1  SRAM read strobe.
REQ-012 SHALL have port rd_addr  output  addr_bw  SRAM read address.
REQ-013 SHALL have port inst_w  output  2  west instruction to the array: bit1 execute, bit0 kernel load.
REQ-014 SHALL have port busy  output  1  run in progress.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-016 SHALL implement states IDLE, KLOAD, GAP, EXEC, DRAIN, DONE; busy=1 exactly in KLOAD, GAP, EXEC and DRAIN.
REQ-017 SHALL, in IDLE with start=1 at an edge, latch len/k_base/x_base and enter KLOAD; start outside IDLE has no effect.
REQ-018 SHALL, in KLOAD, drive rd_en=1 and rd_addr=k_base+i for i=0..row-1, one per non-stalled cycle, then enter GAP.
REQ-019 SHALL hold GAP for exactly one cycle with rd_en=0, then enter EXEC if latched len>0, else DRAIN.
REQ-020 SHALL, in EXEC, drive rd_en=1 and rd_addr=x_base+j for j=0..len-1, one per non-stalled cycle, then enter DRAIN.
REQ-021 SHALL hold DRAIN for row+col non-stalled cycles with rd_en=0, then enter DONE.
REQ-022 SHALL assert done=1 only in DONE, for one cycle, then return to IDLE unconditionally.
REQ-023 SHALL register inst_w: inst_w=2'b01 the cycle after each KLOAD read, 2'b10 the cycle after each EXEC read, else 2'b00 (matches 1-cycle SRAM read latency).
REQ-024 SHALL, with stall=1 in KLOAD/EXEC/DRAIN, freeze state and counters, force rd_en=0 (rd_addr holds), and so produce inst_w=2'b00 the next cycle; stall is ignored in IDLE, GAP and DONE.
REQ-025 SHALL compute addresses modulo 2^addr_bw (wrap past all-ones to 0).
REQ-026 SHALL issue exactly row kernel reads and len execute reads per run regardless of stall pattern.
REQ-027 SHALL drive rd_addr=0 whenever rd_en=0 outside a stall.

Reset
REQ-028 SHALL, on reset=0 at an edge, enter IDLE, clear all counters and latched values, and drive rd_en=0, rd_addr=0, inst_w=2'b00, busy=0, done=0 from the next cycle.
REQ-029 SHALL abandon a run on reset mid-operation without asserting done; the reset takes priority over start and stall in the same cycle.

Verification (row=4, col=4, addr_bw=11)
REQ-030 SHALL be tested: start, len=3, k_base=0x010, x_base=0x100, no stall -> rd_addr 0x010..0x013, 1 gap cycle, 0x100..0x102, 8 drain cycles, done pulse; inst_w 01x4, 00, 10x3 shifted 1 cycle; busy high 16 cycles.
REQ-031 SHALL be tested: len=0 -> 4 kernel reads, GAP, straight to 8 DRAIN cycles, done; inst_w never 2'b10.
REQ-032 SHALL be tested: stall=1 for 2 cycles during EXEC j=1 -> rd_en low 2 cycles, rd_addr held, inst_w 00 for 2 cycles, all 3 exec addresses still issued once, done delayed by 2 cycles.
REQ-033 SHALL be tested: k_base=0x7FE -> kernel addresses 0x7FE, 0x7FF, 0x000, 0x001.
REQ-034 SHALL be tested: reset=0 during EXEC -> next cycle IDLE, all outputs 0, no done; a new start then runs normally.
REQ-035 SHALL be tested: start held high through a whole run and through DONE -> the second run begins only from IDLE, one cycle after done.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - run sequencer for a row x col MAC array fed from single-port SRAM
// Issues kernel-load reads, one gap cycle, execute reads and a drain window, then pulses done.
module mac_seq_ctrl #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         len,
  input  logic [addr_bw-1:0] k_base,
  input  logic [addr_bw-1:0] x_base,
  input  logic               stall,
  output logic               rd_en,
  output logic [addr_bw-1:0] rd_addr,
  output logic [1:0]         inst_w,
  output logic               busy,
  output logic               done
);

  localparam int CW = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_KLOAD = 3'd1,
    S_GAP   = 3'd2,
    S_EXEC  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [7:0]         len_q, len_d;
  logic [addr_bw-1:0] k_base_q, k_base_d;
  logic [addr_bw-1:0] x_base_q, x_base_d;
  logic [1:0]         inst_w_q, inst_w_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      k_base_q <= '0;
      x_base_q <= '0;
      inst_w_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      k_base_q <= k_base_d;
      x_base_q <= x_base_d;
      inst_w_q <= inst_w_d;
    end
  end

  // One shared counter indexes kernel rows, execute vectors and drain cycles in turn.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    k_base_d = k_base_q;
    x_base_d = x_base_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_KLOAD;
          cnt_d    = '0;
          len_d    = len;
          k_base_d = k_base;
          x_base_d = x_base;
        end
      end
      S_KLOAD: begin
        if (!stall) begin
          if (cnt_q == CW'(row - 1)) begin
            state_d = S_GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_GAP: begin
        state_d = (len_q != 8'd0) ? S_EXEC : S_DRAIN;
        cnt_d   = '0;
      end
      S_EXEC: begin
        if (!stall) begin
          if (cnt_q == CW'(len_q) - CW'(1)) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!stall) begin
          if (cnt_q == CW'(row + col - 1)) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // inst_w lags the read strobe by one cycle to line up with SRAM read data.
  always_comb begin
    rd_en    = 1'b0;
    rd_addr  = '0;
    busy     = 1'b0;
    done     = 1'b0;
    inst_w_d = 2'b00;
    case (state_q)
      S_KLOAD: begin
        busy     = 1'b1;
        rd_en    = !stall;
        rd_addr  = k_base_q + addr_bw'(cnt_q);
        inst_w_d = {1'b0, !stall};
      end
      S_GAP: begin
        busy = 1'b1;
      end
      S_EXEC: begin
        busy     = 1'b1;
        rd_en    = !stall;
        rd_addr  = x_base_q + addr_bw'(cnt_q);
        inst_w_d = {!stall, 1'b0};
      end
      S_DRAIN: begin
        busy = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign inst_w = inst_w_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb/tb_mac_seq_ctrl.sv - directed and randomized run checks against a work-list model
module tb_mac_seq_ctrl;

  localparam int ROW = 4;
  localparam int COL = 4;
  localparam int AW  = 11;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    len;
  logic [AW-1:0] k_base;
  logic [AW-1:0] x_base;
  logic          stall;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [1:0]    inst_w;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          kind;
    logic [AW-1:0] addr;
    int          idx;
  } item_t;

  mac_seq_ctrl #(.row(ROW), .col(COL), .addr_bw(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .k_base(k_base), .x_base(x_base), .stall(stall),
    .rd_en(rd_en), .rd_addr(rd_addr), .inst_w(inst_w),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rd_en"},   32'(rd_en),   32'd0);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    chk({tag, "_inst_w"},  32'(inst_w),  32'd0);
    chk({tag, "_busy"},    32'(busy),    32'd0);
    chk({tag, "_done"},    32'(done),    32'd0);
  endtask

  // Kinds: 0 kernel read, 1 gap, 2 execute read, 3 drain, 4 done.
  // smode: 0 no stall, 1 random stall, 2 two stall cycles on execute vector 1.
  task automatic run(input logic [7:0] l, input logic [AW-1:0] kb, input logic [AW-1:0] xb,
                     input int smode, input bit hold, input bit abort,
                     output int busy_cnt, output int stall_cnt);
    item_t q[$];
    item_t it;
    logic [1:0] prev;
    int tgt, kreads, xreads;
    bit s;
    for (int i = 0; i < ROW; i++) q.push_back('{0, kb + AW'(i), i});
    q.push_back('{1, '0, 0});
    for (int j = 0; j < int'(l); j++) q.push_back('{2, xb + AW'(j), j});
    for (int d = 0; d < ROW + COL; d++) q.push_back('{3, '0, d});
    q.push_back('{4, '0, 0});
    start = 1'b1; len = l; k_base = kb; x_base = xb; stall = 1'b0;
    prev = 2'b00; tgt = 0; kreads = 0; xreads = 0; busy_cnt = 0; stall_cnt = 0;
    for (int t = 0; t < 600 && q.size() > 0; t++) begin
      @(posedge clk);
      @(negedge clk);
      if (!hold) start = 1'b0;
      it = q[0];
      s = 1'b0;
      if (it.kind == 0 || it.kind == 2 || it.kind == 3) begin
        if (smode == 1) s = ($urandom_range(0, 3) == 0);
        else if (smode == 2) s = (it.kind == 2 && it.idx == 1 && tgt < 2);
      end
      if (s) begin tgt++; stall_cnt++; end
      stall = s;
      #1;
      chk("rd_en",   32'(rd_en),   32'((it.kind == 0 || it.kind == 2) && !s));
      chk("rd_addr", 32'(rd_addr), (it.kind == 0 || it.kind == 2) ? 32'(it.addr) : 32'd0);
      chk("inst_w",  32'(inst_w),  32'(prev));
      chk("busy",    32'(busy),    32'(it.kind != 4));
      chk("done",    32'(done),    32'(it.kind == 4));
      if (rd_en === 1'b1 && it.kind == 0) kreads++;
      if (rd_en === 1'b1 && it.kind == 2) xreads++;
      if (busy === 1'b1) busy_cnt++;
      if (abort && it.kind == 2 && it.idx == 1) begin
        reset = 1'b0; start = 1'b1; stall = 1'b1;
        return;
      end
      if (s) prev = 2'b00;
      else begin
        prev = (it.kind == 0) ? 2'b01 : (it.kind == 2) ? 2'b10 : 2'b00;
        void'(q.pop_front());
      end
    end
    chk("run_timeout", 32'(q.size()), 32'd0);
    stall = 1'b0;
    chk("kernel_reads", 32'(kreads), 32'(ROW));
    chk("exec_reads",   32'(xreads), 32'(l));
    @(posedge clk);
    @(negedge clk);
    #1;
    chk_idle("post_run");
  endtask

  initial begin
    int bc, sc;
    logic [7:0] rl;
    logic [AW-1:0] rk, rx;
    reset = 1'b0; start = 1'b0; stall = 1'b0; len = '0; k_base = '0; x_base = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk_idle("reset");
    reset = 1'b1;

    run(8'd3, 11'h010, 11'h100, 0, 1'b0, 1'b0, bc, sc);
    chk("busy_cycles_basic", 32'(bc), 32'd16);

    run(8'd0, 11'h020, 11'h200, 0, 1'b0, 1'b0, bc, sc);
    chk("busy_cycles_len0", 32'(bc), 32'd13);

    run(8'd3, 11'h010, 11'h100, 2, 1'b0, 1'b0, bc, sc);
    chk("busy_cycles_stall", 32'(bc), 32'd18);

    run(8'd2, 11'h7FE, 11'h7FF, 0, 1'b0, 1'b0, bc, sc);
    chk("busy_cycles_wrap", 32'(bc), 32'd15);

    run(8'd3, 11'h040, 11'h140, 0, 1'b0, 1'b1, bc, sc);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk_idle("abort");
    reset = 1'b1; start = 1'b0; stall = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("abort_no_done", 32'(done), 32'd0);
    end
    run(8'd3, 11'h050, 11'h150, 0, 1'b0, 1'b0, bc, sc);
    chk("busy_cycles_after_abort", 32'(bc), 32'd16);

    run(8'd2, 11'h060, 11'h160, 0, 1'b1, 1'b0, bc, sc);
    run(8'd1, 11'h070, 11'h170, 0, 1'b1, 1'b0, bc, sc);
    chk("busy_cycles_held_start", 32'(bc), 32'd14);
    start = 1'b0;

    for (int r = 0; r < 8; r++) begin
      rl = 8'($urandom_range(0, 12));
      rk = AW'($urandom_range(0, 2047));
      rx = AW'($urandom_range(2040, 2047));
      run(rl, rk, rx, 1, 1'b0, 1'b0, bc, sc);
      chk("busy_cycles_random", 32'(bc), 32'(ROW + 1 + int'(rl) + ROW + COL + sc));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
